// File: rtl/spi_slave_ctrl.sv
// spi_slave_ctrl: SPI slave command FSM sequencing write, read-address and read-data frames
module spi_slave_ctrl #(
  parameter int TX_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ss_n,
  input  logic                mosi,
  input  logic                rx_valid,
  input  logic                tx_valid,
  input  logic [TX_WIDTH-1:0] tx_data,
  output logic                deser_en,
  output logic                miso,
  output logic                rd_addr_rcvd,
  output logic                busy
);
  localparam int CW = $clog2(TX_WIDTH) + 1;
  typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, READ_WAIT, READ_TX, DONE} state_t;
  state_t state, state_nxt;
  logic [TX_WIDTH-1:0] shift;
  logic [CW-1:0] cnt;
  logic last;
  assign last = cnt == CW'(TX_WIDTH - 1);
  assign deser_en = state == WRITE || state == READ_ADD || state == READ_DATA;
  assign miso = state == READ_TX ? shift[TX_WIDTH-1] : 1'b0;
  assign busy = state != IDLE;
  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nxt;
  // next state; a released slave select always wins and returns to IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      state_nxt = ss_n ? IDLE : CHK_CMD;
      CHK_CMD:   state_nxt = mosi ? (rd_addr_rcvd ? READ_DATA : READ_ADD) : WRITE;
      WRITE:     state_nxt = rx_valid ? DONE : WRITE;
      READ_ADD:  state_nxt = rx_valid ? DONE : READ_ADD;
      READ_DATA: state_nxt = rx_valid ? READ_WAIT : READ_DATA;
      READ_WAIT: state_nxt = tx_valid ? READ_TX : READ_WAIT;
      READ_TX:   state_nxt = last ? DONE : READ_TX;
      DONE:      state_nxt = DONE;
      default:   state_nxt = IDLE;
    endcase
    if (ss_n) state_nxt = IDLE;
  end
  // read-data shifter, bit counter and held-address flag; an abort leaves the flag untouched
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      shift <= '0;
      cnt <= '0;
      rd_addr_rcvd <= 1'b0;
    end else begin
      if (state == READ_WAIT && tx_valid) begin
        shift <= tx_data;
        cnt <= '0;
      end else if (state == READ_TX) begin
        shift <= shift << 1;
        cnt <= cnt + 1'b1;
      end
      if (!ss_n && state == READ_ADD && rx_valid) rd_addr_rcvd <= 1'b1;
      else if (!ss_n && state == READ_TX && last) rd_addr_rcvd <= 1'b0;
    end
endmodule

// File: tb/tb_spi_slave_ctrl.sv
// tb_spi_slave_ctrl: table-driven and directed checks of the SPI slave command FSM
module tb_spi_slave_ctrl;
  logic clk = 1'b0, rst = 1'b0, ss_n = 1'b0, mosi = 1'b0, rx_valid = 1'b0, tx_valid = 1'b0;
  logic [7:0] tx_data = '0;
  logic deser_en, miso, rd_addr_rcvd, busy;
  int n_chk = 0, n_fail = 0;
  typedef struct {
    logic ss, mo, rxv, txv;
    logic [7:0] txd;
    int n;
    logic [3:0] e;
  } vec_t;
  vec_t tbl[$];

  spi_slave_ctrl #(.TX_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .ss_n(ss_n), .mosi(mosi), .rx_valid(rx_valid),
    .tx_valid(tx_valid), .tx_data(tx_data), .deser_en(deser_en), .miso(miso),
    .rd_addr_rcvd(rd_addr_rcvd), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [3:0] e);
    logic [3:0] a;
    a = {deser_en, miso, rd_addr_rcvd, busy};
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: de/miso/rd/busy got %b expected %b", nm, a, e);
    end
  endtask

  task automatic drive(input logic ss, mo, rxv, txv, input logic [7:0] txd);
    ss_n = ss; mosi = mo; rx_valid = rxv; tx_valid = txv; tx_data = txd;
    @(posedge clk);
    #1;
  endtask

  task automatic addr_frame(input string nm);
    drive(0, 1, 0, 0, 0); chk({nm, "_chk"}, 4'b0001);
    drive(0, 1, 0, 0, 0); chk({nm, "_radd"}, 4'b1001);
    repeat (3) drive(0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0); chk({nm, "_done"}, 4'b0011);
    drive(1, 0, 0, 0, 0); chk({nm, "_idle"}, 4'b0010);
  endtask

  task automatic data_to_wait(input string nm, input logic txv, input logic [7:0] txd);
    drive(0, 1, 0, 0, 0); chk({nm, "_chk"}, 4'b0011);
    drive(0, 1, 0, 0, 0); chk({nm, "_rdat"}, 4'b1011);
    repeat (3) drive(0, 0, 0, 0, 0);
    drive(0, 0, 1, txv, txd); chk({nm, "_wait"}, 4'b0011);
    drive(0, 0, 0, 0, 0); chk({nm, "_wait2"}, 4'b0011);
  endtask

  task automatic shift_out(input string nm, input logic [7:0] d);
    drive(0, 0, 0, 1, d);
    for (int i = 7; i >= 0; i--) begin
      chk($sformatf("%s_bit%0d", nm, i), {1'b0, d[i], 2'b11});
      drive(0, 0, 0, 0, 0);
    end
    chk({nm, "_done"}, 4'b0001);
    drive(1, 0, 0, 0, 0); chk({nm, "_idle"}, 4'b0000);
  endtask

  initial begin
    tbl.push_back('{0, 0, 0, 0, 8'h00, 1, 4'b0001});
    tbl.push_back('{0, 0, 0, 0, 8'h00, 1, 4'b1001});
    tbl.push_back('{0, 0, 0, 1, 8'hFF, 1, 4'b1001});
    tbl.push_back('{0, 1, 0, 0, 8'h00, 8, 4'b1001});
    tbl.push_back('{0, 0, 1, 0, 8'h00, 1, 4'b0001});
    tbl.push_back('{0, 0, 1, 1, 8'h00, 1, 4'b0001});
    tbl.push_back('{1, 0, 0, 0, 8'h00, 2, 4'b0000});
    tbl.push_back('{0, 1, 0, 0, 8'h00, 1, 4'b0001});
    tbl.push_back('{0, 1, 0, 0, 8'h00, 1, 4'b1001});
    tbl.push_back('{0, 0, 0, 0, 8'h00, 9, 4'b1001});
    tbl.push_back('{0, 0, 1, 0, 8'h00, 1, 4'b0011});
    tbl.push_back('{1, 0, 0, 0, 8'h00, 1, 4'b0010});
    tbl.push_back('{0, 1, 0, 0, 8'h00, 1, 4'b0011});
    tbl.push_back('{0, 1, 0, 0, 8'h00, 1, 4'b1011});
    tbl.push_back('{0, 0, 0, 0, 8'h00, 9, 4'b1011});
    tbl.push_back('{0, 0, 1, 0, 8'h00, 1, 4'b0011});
    tbl.push_back('{0, 0, 1, 0, 8'h00, 2, 4'b0011});
    tbl.push_back('{0, 0, 0, 1, 8'hA5, 1, 4'b0111});
    tbl.push_back('{0, 0, 0, 0, 8'h00, 1, 4'b0011});
    tbl.push_back('{0, 0, 0, 1, 8'h00, 1, 4'b0111});
    tbl.push_back('{0, 0, 0, 0, 8'h00, 2, 4'b0011});
    tbl.push_back('{0, 0, 0, 0, 8'h00, 1, 4'b0111});
    tbl.push_back('{0, 0, 0, 0, 8'h00, 1, 4'b0011});
    tbl.push_back('{0, 0, 0, 0, 8'h00, 1, 4'b0111});
    tbl.push_back('{0, 0, 0, 0, 8'h00, 2, 4'b0001});
    tbl.push_back('{1, 0, 0, 0, 8'h00, 1, 4'b0000});
    #2;
    chk("reset_async", 4'b0000);
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("reset_hold", 4'b0000);
    end
    ss_n = 1'b1;
    rst = 1'b1;
    foreach (tbl[k])
      repeat (tbl[k].n) begin
        drive(tbl[k].ss, tbl[k].mo, tbl[k].rxv, tbl[k].txv, tbl[k].txd);
        chk($sformatf("vec%0d", k), tbl[k].e);
      end
    addr_frame("abort_addr");
    data_to_wait("abort", 1'b0, 8'h00);
    drive(0, 0, 0, 1, 8'hF0); chk("abort_b7", 4'b0111);
    drive(0, 0, 0, 0, 0); chk("abort_b6", 4'b0111);
    drive(0, 0, 0, 0, 0); chk("abort_b5", 4'b0111);
    drive(1, 0, 0, 0, 0); chk("abort_idle", 4'b0010);
    data_to_wait("retry", 1'b0, 8'h00);
    shift_out("retry", 8'h96);
    addr_frame("coinc_addr");
    data_to_wait("coinc", 1'b1, 8'hFF);
    drive(0, 0, 0, 0, 8'hFF); chk("coinc_wait3", 4'b0011);
    shift_out("coinc", 8'h3C);
    addr_frame("arst_addr");
    data_to_wait("arst", 1'b0, 8'h00);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_immediate", 4'b0000);
    #3;
    ss_n = 1'b0;
    rst = 1'b1;
    drive(0, 1, 0, 0, 0); chk("arst_chk", 4'b0001);
    drive(0, 1, 0, 0, 0); chk("arst_radd", 4'b1001);
    drive(1, 0, 0, 0, 0); chk("arst_idle", 4'b0000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
